mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mips_pkg.sv | 12 +
 rtl/mult_unit.sv | 116 +++++++++++
 tb/tb_mult_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared datapath constants and encodings for the MIPS core.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MULT_WIDTH = DATA_W;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_CALC = 1'b1
    } mult_state_e;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for mult/multu with hi/lo result registers.
// One multiplier bit per cycle; sign is applied to the magnitude product at the end.
module mult_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_e,
    input  logic             signed_e,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             mthi_w,
    input  logic             mtlo_w,
    input  logic [WIDTH-1:0] result_w,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_done
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_e      state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic             sign_q,   sign_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [PW-1:0]    acc_sum_c, final_c;

    // Unsigned magnitudes: -0x80..0 wraps to 0x80..0, which is exactly 2^(WIDTH-1).
    always_comb begin
        mag_a_c   = (signed_e && srca_e[WIDTH-1]) ? -srca_e : srca_e;
        mag_b_c   = (signed_e && srcb_e[WIDTH-1]) ? -srcb_e : srcb_e;
        acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
        final_c   = sign_q ? PW'(~acc_sum_c + PW'(1)) : acc_sum_c;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = done_q;

        case (state_q)
            MULT_IDLE: begin
                if (start_e) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a_c};
                    mplier_d = mag_b_c;
                    sign_d   = signed_e & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    done_d   = 1'b0;
                    state_d  = MULT_CALC;
                end else begin
                    // Move-to writes only land when no multiply is starting.
                    if (mthi_w) hi_d = result_w;
                    if (mtlo_w) lo_d = result_w;
                end
            end
            MULT_CALC: begin
                acc_d    = acc_sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    {hi_d, lo_d} = final_c;
                    cnt_d        = '0;
                    done_d       = 1'b1;
                    state_d      = MULT_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= MULT_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mult_done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit against a plain-arithmetic product model.
module tb_mult_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start_e;
    logic         signed_e;
    logic [W-1:0] srca_e;
    logic [W-1:0] srcb_e;
    logic         mthi_w;
    logic         mtlo_w;
    logic [W-1:0] result_w;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         mult_done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_e   (start_e),
        .signed_e  (signed_e),
        .srca_e    (srca_e),
        .srcb_e    (srcb_e),
        .mthi_w    (mthi_w),
        .mtlo_w    (mtlo_w),
        .result_w  (result_w),
        .hi        (hi),
        .lo        (lo),
        .mult_done (mult_done)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb;
        logic [2*W-1:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one multiply, checks busy length, hi/lo hold, and final product.
    task automatic run_mult(input string name, input logic s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic wb);
        logic [2*W-1:0] prod;
        int cycles;
        prod     = ref_mul(s, a, b);
        signed_e = s;
        srca_e   = a;
        srcb_e   = b;
        start_e  = 1'b1;
        mthi_w   = wb;
        mtlo_w   = wb;
        result_w = 32'h5555_AAAA;
        step();
        start_e  = 1'b0;
        mthi_w   = 1'b0;
        mtlo_w   = 1'b0;
        srca_e   = $urandom;
        srcb_e   = $urandom;
        cycles   = 0;
        while (mult_done === 1'b0 && cycles < 100) begin
            cycles++;
            checks++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("FAIL %s hold: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo,
                         exp_hi, exp_lo);
            end
            step();
        end
        checks++;
        if (cycles != 32) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 32", name, cycles);
        end
        exp_hi = prod[2*W-1:W];
        exp_lo = prod[W-1:0];
        checks++;
        if (hi !== exp_hi || lo !== exp_lo || mult_done !== 1'b1) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h done=%b expected hi=%h lo=%h done=1",
                     name, hi, lo, mult_done, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (mult_done !== 1'b1 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset: done=%b hi=%h lo=%h expected done=1 hi=0 lo=0",
                     mult_done, hi, lo);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        exp_hi = '0;
        exp_lo = '0;
        checks++;
        if (mult_done !== 1'b1 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_release: done=%b hi=%h lo=%h expected done=1 hi=0 lo=0",
                     mult_done, hi, lo);
        end
    endtask

    task automatic test_directed();
        run_mult("u_3x5", 1'b0, 32'd3, 32'd5, 1'b0);
        run_mult("s_m1x1", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_mult("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mult("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_mult("s_min_x_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_mult("s_zero", 1'b1, 32'h0, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [W-1:0] corners [4] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            run_mult($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_mult("b2b_a", 1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0);
        run_mult("b2b_b", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    endtask

    task automatic test_reset_mid();
        signed_e = 1'b0;
        srca_e   = 32'd1000;
        srcb_e   = 32'd1000;
        start_e  = 1'b1;
        step();
        start_e = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mult_done !== 1'b1 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL mid_reset: done=%b hi=%h lo=%h expected done=1 hi=0 lo=0",
                     mult_done, hi, lo);
        end
        step();
        reset_n = 1'b1;
        exp_hi  = '0;
        exp_lo  = '0;
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (mult_done !== 1'b1 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL no_resume: done=%b hi=%h lo=%h expected done=1 hi=0 lo=0",
                     mult_done, hi, lo);
        end
        run_mult("after_reset_2x7", 1'b0, 32'd2, 32'd7, 1'b0);
    endtask

    task automatic test_ignore_start();
        int cycles;
        signed_e = 1'b0;
        srca_e   = 32'd2;
        srcb_e   = 32'd2;
        start_e  = 1'b1;
        step();
        start_e = 1'b0;
        cycles  = 0;
        while (mult_done === 1'b0 && cycles < 100) begin
            cycles++;
            if (cycles == 5) begin
                start_e  = 1'b1;
                signed_e = 1'b1;
                srca_e   = 32'd9;
                srcb_e   = 32'd9;
                mthi_w   = 1'b1;
                result_w = 32'h1234;
            end else begin
                start_e = 1'b0;
                mthi_w  = 1'b0;
            end
            step();
        end
        start_e = 1'b0;
        mthi_w  = 1'b0;
        exp_hi  = '0;
        exp_lo  = 32'd4;
        checks++;
        if (cycles != 32 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL ignore_start: cycles=%0d hi=%h lo=%h expected 32 hi=0 lo=4",
                     cycles, hi, lo);
        end
        step();
        checks++;
        if (mult_done !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL ignore_start_idle: done=%b hi=%h lo=%h expected done=1 hi=0 lo=4",
                     mult_done, hi, lo);
        end
    endtask

    task automatic test_move_to();
        mtlo_w   = 1'b1;
        result_w = 32'hABCD;
        step();
        mtlo_w = 1'b0;
        exp_lo = 32'hABCD;
        checks++;
        if (lo !== exp_lo || hi !== exp_hi || mult_done !== 1'b1) begin
            errors++;
            $display("FAIL mtlo: lo=%h hi=%h done=%b expected lo=%h hi=%h done=1",
                     lo, hi, mult_done, exp_lo, exp_hi);
        end
        mthi_w   = 1'b1;
        result_w = 32'h0BAD_F00D;
        step();
        mthi_w = 1'b0;
        exp_hi = 32'h0BAD_F00D;
        checks++;
        if (lo !== exp_lo || hi !== exp_hi) begin
            errors++;
            $display("FAIL mthi: lo=%h hi=%h expected lo=%h hi=%h", lo, hi, exp_lo, exp_hi);
        end
        mthi_w   = 1'b1;
        mtlo_w   = 1'b1;
        result_w = 32'hC0FF_EE11;
        step();
        mthi_w = 1'b0;
        mtlo_w = 1'b0;
        exp_hi = 32'hC0FF_EE11;
        exp_lo = 32'hC0FF_EE11;
        checks++;
        if (lo !== exp_lo || hi !== exp_hi) begin
            errors++;
            $display("FAIL mthi_mtlo: lo=%h hi=%h expected lo=%h hi=%h", lo, hi, exp_lo, exp_hi);
        end
        run_mult("start_beats_mt", 1'b0, 32'd3, 32'd3, 1'b1);
    endtask

    initial begin
        reset_n  = 1'b1;
        start_e  = 1'b0;
        signed_e = 1'b0;
        srca_e   = '0;
        srcb_e   = '0;
        mthi_w   = 1'b0;
        mtlo_w   = 1'b0;
        result_w = '0;
        #2;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_ignore_start();
        test_move_to();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
